// File: rtl/othello_pkg.sv
// Shared Othello encodings, board geometry, direction steps and sequencer states.
package othello_pkg;

  localparam int unsigned BOARD_W = 10;

  localparam logic [1:0] EMPTY  = 2'b00;
  localparam logic [1:0] BLACK  = 2'b01;
  localparam logic [1:0] WHITE  = 2'b10;
  localparam logic [1:0] BORDER = 2'b11;

  // Step for direction d on a board of row pitch w, as 5-bit two's complement.
  function automatic logic [4:0] step_for(input int w, input logic [2:0] d);
    int s;
    case (d)
      3'd0:    s = -(w + 1);
      3'd1:    s = -w;
      3'd2:    s = -(w - 1);
      3'd3:    s = -1;
      3'd4:    s = 1;
      3'd5:    s = w - 1;
      3'd6:    s = w;
      default: s = w + 1;
    endcase
    return 5'(s);
  endfunction

  localparam logic [4:0] DIR_STEP [8] = '{
    step_for(BOARD_W, 3'd0), step_for(BOARD_W, 3'd1), step_for(BOARD_W, 3'd2),
    step_for(BOARD_W, 3'd3), step_for(BOARD_W, 3'd4), step_for(BOARD_W, 3'd5),
    step_for(BOARD_W, 3'd6), step_for(BOARD_W, 3'd7)
  };

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_START, S_WAIT, S_NEXT, S_DECIDE,
    S_PLACE, S_FLIP_SEL, S_FLIP_RD, S_FLIP_CHK, S_DONE
  } state_t;

  function automatic logic [2:0] lowest_set(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dir_step_rom.sv
// Combinational direction index to 5-bit signed address step.
module dir_step_rom
  import othello_pkg::*;
#(
  parameter int unsigned BOARD_W = othello_pkg::BOARD_W
) (
  input  logic [2:0] dir,
  output logic [4:0] step
);

  always_comb begin
    step = step_for(int'(BOARD_W), dir);
  end

endmodule

// File: rtl/move_sequencer.sv
// Runs the validator over all eight directions, then places the piece and flips
// every legal run, owning the single board-RAM port.
module move_sequencer
  import othello_pkg::*;
#(
  parameter int unsigned BOARD_W      = othello_pkg::BOARD_W,
  parameter int unsigned MAX_RUN      = 8,
  parameter int unsigned VALI_TIMEOUT = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] move_addr,
  input  logic       player,
  output logic       busy,
  output logic       done,
  output logic       legal,
  output logic [7:0] dir_mask,
  output logic [5:0] flip_count,
  output logic       vali_ld,
  output logic [4:0] vali_step,
  output logic       vali_en,
  input  logic       vali_done,
  input  logic       vali_dir_ok,
  input  logic [6:0] vali_addr,
  input  logic       vali_wren,
  output logic [6:0] mem_addr,
  output logic       mem_wren,
  output logic [1:0] mem_wdata,
  input  logic [1:0] mem_rdata
);

  localparam int unsigned RW = $clog2(MAX_RUN + 1);
  localparam int unsigned TW = $clog2(VALI_TIMEOUT + 1);

  state_t          state_q;
  logic [2:0]      d_q;
  logic [6:0]      move_q;
  logic            player_q;
  logic [7:0]      pend_q;
  logic [6:0]      cur_q;
  logic [RW-1:0]   run_q;
  logic [TW-1:0]   tmo_q;

  logic [1:0]      own_col;
  logic [1:0]      opp_col;
  logic [2:0]      sel_dir;
  logic [2:0]      rom_dir;
  logic [4:0]      step;
  logic [6:0]      step_ext;
  logic            flip_hit;

  assign own_col  = player_q ? WHITE : BLACK;
  assign opp_col  = player_q ? BLACK : WHITE;
  assign sel_dir  = lowest_set(pend_q);
  assign step_ext = {{2{step[4]}}, step};
  assign flip_hit = (state_q == S_FLIP_CHK) && (mem_rdata == opp_col) &&
                    (run_q < RW'(MAX_RUN));

  // The ROM is indexed by the direction the next state will use.
  always_comb begin
    rom_dir = d_q;
    case (state_q)
      S_IDLE:     rom_dir = 3'd0;
      S_NEXT:     rom_dir = d_q + 3'd1;
      S_FLIP_SEL: rom_dir = sel_dir;
      default:    rom_dir = d_q;
    endcase
  end

  dir_step_rom #(
    .BOARD_W (BOARD_W)
  ) u_dir_step_rom (
    .dir  (rom_dir),
    .step (step)
  );

  always_comb begin
    mem_addr  = '0;
    mem_wren  = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_START, S_WAIT: begin
        mem_addr = vali_addr;
        mem_wren = vali_wren;
      end
      S_PLACE: begin
        mem_addr  = move_q;
        mem_wren  = 1'b1;
        mem_wdata = own_col;
      end
      S_FLIP_RD: begin
        mem_addr = cur_q;
      end
      S_FLIP_CHK: begin
        mem_addr  = cur_q;
        mem_wren  = flip_hit;
        mem_wdata = own_col;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      d_q        <= '0;
      move_q     <= '0;
      player_q   <= 1'b0;
      pend_q     <= '0;
      cur_q      <= '0;
      run_q      <= '0;
      tmo_q      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      legal      <= 1'b0;
      dir_mask   <= '0;
      flip_count <= '0;
      vali_ld    <= 1'b0;
      vali_en    <= 1'b0;
      vali_step  <= '0;
    end else begin
      vali_ld <= 1'b0;
      vali_en <= 1'b0;
      done    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            move_q     <= move_addr;
            player_q   <= player;
            dir_mask   <= '0;
            flip_count <= '0;
            legal      <= 1'b0;
            d_q        <= '0;
            busy       <= 1'b1;
            vali_ld    <= 1'b1;
            vali_step  <= step;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD: begin
          vali_en <= 1'b1;
          tmo_q   <= '0;
          state_q <= S_START;
        end
        S_START: state_q <= S_WAIT;
        S_WAIT: begin
          if (vali_done) begin
            dir_mask[d_q] <= vali_dir_ok;
            state_q       <= S_NEXT;
          end else if (tmo_q == TW'(VALI_TIMEOUT - 1)) begin
            state_q <= S_NEXT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (d_q == 3'd7) begin
            state_q <= S_DECIDE;
          end else begin
            d_q       <= d_q + 3'd1;
            vali_ld   <= 1'b1;
            vali_step <= step;
            state_q   <= S_LOAD;
          end
        end
        S_DECIDE: begin
          if (dir_mask == 8'd0) begin
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            legal   <= 1'b1;
            pend_q  <= dir_mask;
            state_q <= S_PLACE;
          end
        end
        S_PLACE: begin
          d_q     <= '0;
          state_q <= S_FLIP_SEL;
        end
        S_FLIP_SEL: begin
          if (pend_q == 8'd0) begin
            done    <= 1'b1;
            state_q <= S_DONE;
          end else begin
            d_q             <= sel_dir;
            pend_q[sel_dir] <= 1'b0;
            cur_q           <= move_q + step_ext;
            run_q           <= '0;
            state_q         <= S_FLIP_RD;
          end
        end
        S_FLIP_RD: state_q <= S_FLIP_CHK;
        S_FLIP_CHK: begin
          if (flip_hit) begin
            flip_count <= flip_count + 6'd1;
            cur_q      <= cur_q + step_ext;
            run_q      <= run_q + 1'b1;
            state_q    <= S_FLIP_RD;
          end else begin
            state_q <= S_FLIP_SEL;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_sequencer.sv
// Directed bench for move_sequencer with a behavioural validator, board RAM and scoreboard.
module tb_move_sequencer;

  localparam logic [1:0] EMP = 2'b00;
  localparam logic [1:0] BLK = 2'b01;
  localparam logic [1:0] WHT = 2'b10;
  localparam logic [1:0] BRD = 2'b11;

  typedef struct packed {
    logic       legal;
    logic [7:0] mask;
    logic [5:0] flips;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [6:0] move_addr = '0;
  logic       player = 1'b0;
  logic       busy, done, legal;
  logic [7:0] dir_mask;
  logic [5:0] flip_count;
  logic       vali_ld, vali_en;
  logic [4:0] vali_step;
  logic       vali_done = 1'b0;
  logic       vali_dir_ok = 1'b0;
  logic [6:0] vali_addr = 7'h55;
  logic       vali_wren = 1'b0;
  logic [6:0] mem_addr;
  logic       mem_wren;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata = '0;

  int         checks = 0;
  int         failures = 0;
  exp_t       sb[$];
  logic [1:0] mb  [128];
  logic [1:0] eb  [128];
  logic [1:0] ram [128];
  int         steps [8] = '{-11, -10, -9, -1, 1, 9, 10, 11};
  int         cur_move = 0;
  bit         cur_pl = 1'b0;
  bit         drop_en = 1'b0;
  logic [4:0] drop_step = 5'h17;
  bit         do_load = 1'b0;
  int         wr_cnt = 0;
  int         wr_base = 0;
  logic [4:0] m_step = '0;
  bit         m_ok = 1'b0;
  bit         m_drop = 1'b0;
  bit         m_pend = 1'b0;

  move_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .move_addr   (move_addr),
    .player      (player),
    .busy        (busy),
    .done        (done),
    .legal       (legal),
    .dir_mask    (dir_mask),
    .flip_count  (flip_count),
    .vali_ld     (vali_ld),
    .vali_step   (vali_step),
    .vali_en     (vali_en),
    .vali_done   (vali_done),
    .vali_dir_ok (vali_dir_ok),
    .vali_addr   (vali_addr),
    .vali_wren   (vali_wren),
    .mem_addr    (mem_addr),
    .mem_wren    (mem_wren),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  always #5 clock = ~clock;

  // Reference direction check on the pre-move board.
  function automatic bit dir_legal(input int pos, input int s, input logic [1:0] own);
    logic [1:0] opp;
    int p;
    int n;
    opp = (own == BLK) ? WHT : BLK;
    if (mb[pos] != EMP) return 1'b0;
    p = (pos + s) & 127;
    n = 0;
    while (mb[p] == opp && n < 8) begin
      p = (p + s) & 127;
      n++;
    end
    return (n > 0) && (mb[p] == own);
  endfunction

  // Board RAM: synchronous read, one-cycle latency.
  always @(posedge clock) begin
    if (do_load) begin
      for (int i = 0; i < 128; i++) ram[i] <= mb[i];
    end else if (mem_wren) begin
      ram[mem_addr] <= mem_wdata;
    end
    mem_rdata <= ram[mem_addr];
    if (mem_wren) wr_cnt <= wr_cnt + 1;
  end

  // Validator model: vali_done two cycles after vali_en, optionally withheld.
  always @(posedge clock) begin
    vali_done <= 1'b0;
    if (vali_ld) m_step <= vali_step;
    if (vali_en) begin
      m_ok   <= dir_legal(cur_move, int'($signed(m_step)), cur_pl ? WHT : BLK);
      m_drop <= drop_en && (m_step == drop_step);
      m_pend <= 1'b1;
    end else if (m_pend) begin
      m_pend <= 1'b0;
      if (!m_drop) begin
        vali_done   <= 1'b1;
        vali_dir_ok <= m_ok;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outs(input string tag);
    chk({tag, "_ctl"}, {busy, done, legal, vali_ld, vali_en, mem_wren}, 32'd0);
    chk({tag, "_dir_mask"}, dir_mask, 32'd0);
    chk({tag, "_flip_count"}, flip_count, 32'd0);
    chk({tag, "_vali_step"}, vali_step, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  task automatic board_clear();
    int r;
    int c;
    for (int i = 0; i < 128; i++) begin
      r = i / 10;
      c = i % 10;
      mb[i] = (r >= 1 && r <= 8 && c >= 1 && c <= 8) ? EMP : BRD;
    end
  endtask

  task automatic board_opening();
    board_clear();
    mb[44] = WHT; mb[45] = BLK; mb[54] = BLK; mb[55] = WHT;
  endtask

  task automatic board_two_runs();
    board_clear();
    mb[33] = WHT; mb[22] = WHT; mb[11] = BLK;
    mb[55] = WHT; mb[66] = WHT; mb[77] = WHT; mb[88] = BLK;
  endtask

  task automatic board_load();
    @(negedge clock);
    do_load = 1'b1;
    @(negedge clock);
    do_load = 1'b0;
  endtask

  task automatic apply_move(input int pos, input bit pl, input logic [7:0] m);
    logic [1:0] own;
    logic [1:0] opp;
    int p;
    int n;
    own = pl ? WHT : BLK;
    opp = pl ? BLK : WHT;
    eb[pos] = own;
    for (int d = 0; d < 8; d++) begin
      if (m[d]) begin
        p = (pos + steps[d]) & 127;
        n = 0;
        while (eb[p] == opp && n < 8) begin
          eb[p] = own;
          n++;
          p = (p + steps[d]) & 127;
        end
      end
    end
  endtask

  task automatic start_move(input string tag, input int pos, input bit pl, input bit push,
                            input logic l, input logic [7:0] m, input logic [5:0] f);
    exp_t e;
    cur_move = pos;
    cur_pl   = pl;
    for (int i = 0; i < 128; i++) eb[i] = mb[i];
    if (l) apply_move(pos, pl, m);
    if (push) begin
      e.legal = l;
      e.mask  = m;
      e.flips = f;
      sb.push_back(e);
    end
    wr_base = wr_cnt;
    @(negedge clock);
    move_addr = 7'(pos);
    player    = pl;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk({tag, "_load"}, {vali_ld, vali_step}, {26'd0, 1'b1, 5'h15});
  endtask

  task automatic wait_done(input string tag, input bit glitch, output int cyc);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    cyc  = 0;
    for (int i = 2; i < 2000 && !seen; i++) begin
      @(negedge clock);
      if (i == 2) chk({tag, "_vali_en"}, vali_en, 32'd1);
      if (i == 3) chk({tag, "_mux"}, {mem_wren, mem_addr}, {24'd0, 1'b0, 7'h55});
      if (glitch && i == 5) begin
        start     = 1'b1;
        move_addr = 7'd33;
        player    = 1'b1;
      end
      if (done) begin
        seen = 1'b1;
        cyc  = i;
        chk({tag, "_sb_nonempty"}, sb.size() != 0, 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk({tag, "_legal"}, legal, e.legal);
          chk({tag, "_dir_mask"}, dir_mask, e.mask);
          chk({tag, "_flip_count"}, flip_count, e.flips);
        end
        if (glitch) begin
          @(posedge clock);
          #1;
          start     = 1'b0;
          move_addr = 7'd34;
          player    = 1'b0;
          chk({tag, "_start_at_done"}, busy, 32'd0);
          @(negedge clock);
          chk({tag, "_stays_idle"}, busy, 32'd0);
        end
      end
    end
    chk({tag, "_done_seen"}, seen, 32'd1);
  endtask

  task automatic run_case(input string tag, input int pos, input bit pl, input bit glitch,
                          input logic l, input logic [7:0] m, input logic [5:0] f,
                          input int cyc_exp);
    int cyc;
    int mism;
    start_move(tag, pos, pl, 1'b1, l, m, f);
    wait_done(tag, glitch, cyc);
    if (cyc_exp != 0) chk({tag, "_done_cycle"}, cyc, cyc_exp);
    chk({tag, "_writes"}, wr_cnt - wr_base, l ? 32'(f) + 32'd1 : 32'd0);
    mism = 0;
    for (int i = 0; i < 128; i++) begin
      if (ram[i] !== eb[i]) mism++;
    end
    chk({tag, "_board"}, mism, 32'd0);
  endtask

  initial begin
    bit hit;

    repeat (2) @(negedge clock);
    check_reset_outs("reset");
    reset = 1'b0;
    @(negedge clock);
    chk("reset_release_busy", busy, 32'd0);

    board_opening();
    board_load();
    run_case("open34", 34, 1'b0, 1'b0, 1'b1, 8'b0100_0000, 6'd1, 49);
    chk("open34_ram34", ram[34], BLK);
    chk("open34_ram44", ram[44], BLK);

    board_opening();
    board_load();
    run_case("open33", 33, 1'b0, 1'b0, 1'b0, 8'b0000_0000, 6'd0, 42);

    board_two_runs();
    board_load();
    run_case("tworuns", 44, 1'b0, 1'b0, 1'b1, 8'b1000_0001, 6'd5, 60);
    chk("tworuns_stop_own", ram[88], BLK);

    // Direction 2 would be legal but its vali_done is withheld.
    board_clear();
    mb[46] = WHT; mb[37] = BLK; mb[66] = WHT; mb[77] = BLK;
    board_load();
    drop_en = 1'b1;
    run_case("timeout", 55, 1'b0, 1'b0, 1'b1, 8'b1000_0000, 6'd1, 0);
    drop_en = 1'b0;
    chk("timeout_ram46", ram[46], WHT);

    board_two_runs();
    board_load();
    start_move("rstmid", 44, 1'b0, 1'b0, 1'b0, 8'd0, 6'd0);
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clock);
      if (mem_wren && mem_addr != 7'd44) hit = 1'b1;
    end
    chk("rstmid_flip_reached", hit, 32'd1);
    reset = 1'b1;
    #1;
    check_reset_outs("rstmid");
    @(negedge clock);
    reset = 1'b0;

    board_opening();
    board_load();
    run_case("after_rst", 34, 1'b0, 1'b0, 1'b1, 8'b0100_0000, 6'd1, 49);

    board_opening();
    board_load();
    run_case("glitch", 34, 1'b0, 1'b1, 1'b1, 8'b0100_0000, 6'd1, 49);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Sequences a complete Othello move for the datapath. Given a target cell and the player, it drives the direction validator through all eight directions and collects an 8-bit legal-direction mask. If any direction is legal, it places the piece and flips the opponent runs along every legal direction. It owns the single board-RAM port and muxes it between the validator and its own place/flip writes.

## Interface
- BOARD_W, 10: padded board row pitch; playable cells are rows/cols 1..8, border cells hold 2'b11.
- MAX_RUN, 8: maximum cells walked per flip direction.
- VALI_TIMEOUT, 20: cycles allowed in S_WAIT before the direction counts as illegal.
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; forces S_IDLE.
- start  in  1  one-cycle request; accepted only in S_IDLE.
- move_addr  in  7  target cell, row*BOARD_W+col.
- player  in  1  0 = black (writes 2'b01), 1 = white (writes 2'b10).
- busy  out  1  high from start acceptance until the cycle after done.
- done  out  1  one-cycle pulse at the end of every move attempt.
- legal  out  1  valid with done and held until the next start.
- dir_mask  out  8  bit d set = direction d legal; held like legal.
- flip_count  out  6  cells flipped, excluding the placed cell.
- vali_ld  out  1  one-cycle load strobe to the validator.
- vali_step  out  5  direction step in two's complement.
- vali_en  out  1  one-cycle start pulse to the validator.
- vali_done  in  1  validator completion pulse.
- vali_dir_ok  in  1  validator result, sampled with vali_done.
- vali_addr  in  7  validator RAM address.
- vali_wren  in  1  validator write enable.
- mem_addr  out  7  board RAM address after the mux.
- mem_wren  out  1  board RAM write enable after the mux.
- mem_wdata  out  2  board RAM write data.
- mem_rdata  in  2  board RAM read data, valid one cycle after the address.

## Operation
- Cell encoding: 00 empty, 01 black, 10 white, 11 border.
- Direction index d ↔ step:
  - 0: −11, 1: −10, 2: −9, 3: −1
  - 4: +1, 5: +9, 6: +10, 7: +11
- Address arithmetic is 7-bit modulo 128 with the step sign-extended.
- States and transitions:
  - S_IDLE: on start, latch move_addr and player, clear dir_mask and flip_count, d=0 → S_LOAD.
  - S_LOAD: vali_ld=1, vali_step=step(d) → S_START.
  - S_START: vali_en=1, clear the timeout counter → S_WAIT.
  - S_WAIT: on vali_done, set dir_mask[d]=vali_dir_ok → S_NEXT. If the timeout counter reaches VALI_TIMEOUT, leave the bit at 0 → S_NEXT.
  - S_NEXT: if d==7 → S_DECIDE; otherwise d+1 → S_LOAD.
  - S_DECIDE: mask==0 → S_DONE with legal=0; otherwise legal=1 → S_PLACE.
  - S_PLACE: write own colour at move_addr, d=0 → S_FLIP_SEL.
  - S_FLIP_SEL: advance d to the next set mask bit. If none remain → S_DONE. Otherwise set cur = move_addr + step(d), run = 0 → S_FLIP_RD.
  - S_FLIP_RD: present cur with wren=0 → S_FLIP_CHK.
  - S_FLIP_CHK: if mem_rdata is opponent and run<MAX_RUN, write own colour at cur, flip_count+1, cur+=step, run+1 → S_FLIP_RD. Otherwise → S_FLIP_SEL.
  - S_DONE: done=1 → S_IDLE.
- RAM mux: in S_START and S_WAIT the port is granted to vali_addr/vali_wren. In all other states the block drives the port itself, with wren=0 except during place/flip writes.

## Timing
- Reset values:
  - busy=0, done=0, legal=0.
  - dir_mask=0, flip_count=0.
  - vali_ld=0, vali_en=0, vali_step=0.
  - mem_wren=0, mem_addr=0, mem_wdata=0.
- Per direction: 3 cycles plus validator latency.
- Illegal move: done asserted 8×(3+Lv)+2 cycles after the start cycle, where Lv is the validator latency.
- Flip cost: 2 cycles per cell examined.
- start outside S_IDLE is ignored. A start in the same cycle as done is ignored; done returns to S_IDLE first.
- vali_done outside S_WAIT is ignored.
- Reset mid-move returns to S_IDLE immediately and drops mem_wren. Partial writes are not undone.
- A border cell (11) or an empty cell terminates a flip run. MAX_RUN bounds the run even on corrupt boards.
- A move_addr that is already occupied is not rejected here; the validator reports every direction illegal for it.

## Structure
- Shared package othello_pkg holds:
  - cell encodings (EMPTY, BLACK, WHITE, BORDER);
  - BOARD_W;
  - the direction→step constant table;
  - state localparams.
- Sub-module dir_step_rom: combinational map from d to the 5-bit step, shared with the validator bench.

## Test plan
- Standard opening, black (player=0), move_addr=34: dir_mask=8'b0100_0000, legal=1, flip_count=1; RAM[34]=01, RAM[44]=01.
- Same board, move_addr=33: all eight directions return dir_ok=0, legal=0, no RAM write at any point, done after 8 direction cycles.
- Directions 0 and 7 both legal, with run lengths 2 and 3: flip_count=5, both runs overwritten with own colour, stops at own piece.
- Validator never pulses vali_done on d=2: bit 2 is cleared after VALI_TIMEOUT cycles and the sequence continues to d=7.
- Reset asserted during S_FLIP_CHK: the next cycle shows busy=0, mem_wren=0, all outputs at reset values; a new start then works normally.
- start pulsed while busy, and again in the same cycle as done: both ignored; latched move_addr and player are unchanged.
